// File: rtl/vending_pkg.sv
// Shared coin encodings, coin values and controller state encodings
// for the vending machine credit path.
package vending_pkg;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_25  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam int unsigned CENTS_5  = 5;
    localparam int unsigned CENTS_10 = 10;
    localparam int unsigned CENTS_25 = 25;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_e;

    // Cent value of a coin code; the invalid code is worth nothing.
    function automatic int unsigned coin_cents(input logic [1:0] code);
        int unsigned cents;
        case (code)
            COIN_5:  cents = CENTS_5;
            COIN_10: cents = CENTS_10;
            COIN_25: cents = CENTS_25;
            default: cents = 0;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/vend_timeout_counter.sv
// Cycle counter for the VEND dwell; term_c is high while the count sits
// at TIMEOUT-1 so the controller aborts on the following edge.
module vend_timeout_counter #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic term_c
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_c = enable_i && (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/vend_credit_fsm.sv
// Coin-credit controller: accumulates coins, authorises vends, pulses the
// dispense flip-flop set/clear inputs and hands out change or refunds.
module vend_credit_fsm
    import vending_pkg::*;
#(
    parameter int unsigned PRICE      = 50,
    parameter int unsigned CREDIT_MAX = 200,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned CW         = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          coin_valid,
    input  logic [1:0]    coin_code,
    input  logic          select,
    input  logic          cancel,
    input  logic          dispense_done,
    input  logic          change_ack,
    output logic          latch_set,
    output logic          latch_clr,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          change_valid,
    output logic [CW-1:0] change_amount,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] amount_q, amount_d;
    logic          cv_q, cv_d;
    logic          set_q, set_d;
    logic          clr_q, clr_d;
    logic          rej_q, rej_d;
    logic          busy_q, busy_d;

    logic          timeout_c;
    logic [CW:0]   sum_c;
    logic          coin_ok_c;
    logic          accept_c;
    logic [CW-1:0] remainder_c;

    vend_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (state_q != ST_VEND),
        .enable_i (state_q == ST_VEND),
        .term_c   (timeout_c)
    );

    // Wide sum so a coin that would overflow CW bits is still caught.
    assign sum_c       = {1'b0, credit_q} + (CW+1)'(coin_cents(coin_code));
    assign coin_ok_c   = coin_valid && (coin_code != COIN_BAD)
                         && (sum_c <= (CW+1)'(CREDIT_MAX));
    assign remainder_c = credit_q - CW'(PRICE);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        amount_d = amount_q;
        cv_d     = cv_q;
        set_d    = 1'b0;
        clr_d    = 1'b0;
        accept_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_ok_c) begin
                    credit_d = sum_c[CW-1:0];
                    accept_c = 1'b1;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    amount_d = credit_q;
                    cv_d     = 1'b1;
                    state_d  = ST_CHANGE;
                end else if (select && (credit_q >= CW'(PRICE))) begin
                    set_d   = 1'b1;
                    state_d = ST_VEND;
                end else if (coin_ok_c) begin
                    credit_d = sum_c[CW-1:0];
                    accept_c = 1'b1;
                end
            end
            ST_VEND: begin
                // A drop reported on the timeout cycle still counts as a vend.
                if (dispense_done) begin
                    clr_d    = 1'b1;
                    credit_d = remainder_c;
                    if (remainder_c != '0) begin
                        amount_d = remainder_c;
                        cv_d     = 1'b1;
                        state_d  = ST_CHANGE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timeout_c) begin
                    clr_d    = 1'b1;
                    amount_d = credit_q;
                    cv_d     = 1'b1;
                    state_d  = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                if (change_ack) begin
                    credit_d = '0;
                    amount_d = '0;
                    cv_d     = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rej_d  = coin_valid && !accept_c;
        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            amount_q <= '0;
            cv_q     <= 1'b0;
            set_q    <= 1'b0;
            clr_q    <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            amount_q <= amount_d;
            cv_q     <= cv_d;
            set_q    <= set_d;
            clr_q    <= clr_d;
            rej_q    <= rej_d;
            busy_q   <= busy_d;
        end
    end

    assign latch_set     = set_q;
    assign latch_clr     = clr_q;
    assign coin_reject   = rej_q;
    assign credit        = credit_q;
    assign change_valid  = cv_q;
    assign change_amount = amount_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed self-checking bench for vend_credit_fsm with TIMEOUT = 8.
module tb_vend_credit_fsm;

    localparam int unsigned CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_code = 2'b00;
    logic          select = 1'b0;
    logic          cancel = 1'b0;
    logic          dispense_done = 1'b0;
    logic          change_ack = 1'b0;
    logic          latch_set;
    logic          latch_clr;
    logic          coin_reject;
    logic [CW-1:0] credit;
    logic          change_valid;
    logic [CW-1:0] change_amount;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    vend_credit_fsm #(
        .PRICE      (50),
        .CREDIT_MAX (200),
        .TIMEOUT    (8),
        .CW         (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .select        (select),
        .cancel        (cancel),
        .dispense_done (dispense_done),
        .change_ack    (change_ack),
        .latch_set     (latch_set),
        .latch_clr     (latch_clr),
        .coin_reject   (coin_reject),
        .credit        (credit),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic ls, input logic lc, input logic rej,
                           input int cred, input logic cv, input int amt, input logic bsy);
        chk({tag, ".latch_set"},     32'(latch_set),     32'(ls));
        chk({tag, ".latch_clr"},     32'(latch_clr),     32'(lc));
        chk({tag, ".coin_reject"},   32'(coin_reject),   32'(rej));
        chk({tag, ".credit"},        32'(credit),        32'(cred));
        chk({tag, ".change_valid"},  32'(change_valid),  32'(cv));
        chk({tag, ".change_amount"}, 32'(change_amount), 32'(amt));
        chk({tag, ".busy"},          32'(busy),          32'(bsy));
    endtask

    // Outputs are read 1 time unit after the edge that produced them.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic pulse_select();
        select = 1'b1;
        step();
        select = 1'b0;
    endtask

    task automatic pulse_ack();
        change_ack = 1'b1;
        step();
        change_ack = 1'b0;
    endtask

    initial begin
        // Reset
        step();
        step();
        exp_out("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Exact-price vend, no change
        coin(2'b10);
        exp_out("c25a", 0, 0, 0, 25, 0, 0, 0);
        coin(2'b10);
        exp_out("c25b", 0, 0, 0, 50, 0, 0, 0);
        pulse_select();
        exp_out("sel50", 1, 0, 0, 50, 0, 0, 1);
        step();
        exp_out("vend_hold", 0, 0, 0, 50, 0, 0, 1);
        dispense_done = 1'b1;
        step();
        dispense_done = 1'b0;
        exp_out("drop50", 0, 1, 0, 0, 0, 0, 0);
        step();
        exp_out("idle50", 0, 0, 0, 0, 0, 0, 0);

        // Vend with 10c change
        coin(2'b10);
        coin(2'b10);
        coin(2'b01);
        exp_out("c60", 0, 0, 0, 60, 0, 0, 0);
        pulse_select();
        exp_out("sel60", 1, 0, 0, 60, 0, 0, 1);
        dispense_done = 1'b1;
        step();
        dispense_done = 1'b0;
        exp_out("drop60", 0, 1, 0, 10, 1, 10, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_out("chg_hold", 0, 0, 0, 10, 1, 10, 1);
        end
        pulse_ack();
        exp_out("chg_ack", 0, 0, 0, 0, 0, 0, 0);

        // Overflow and invalid coins
        for (int i = 0; i < 7; i++) coin(2'b10);
        coin(2'b01);
        coin(2'b00);
        exp_out("c190", 0, 0, 0, 190, 0, 0, 0);
        coin(2'b10);
        exp_out("ovf", 0, 0, 1, 190, 0, 0, 0);
        step();
        exp_out("ovf_after", 0, 0, 0, 190, 0, 0, 0);
        coin(2'b11);
        exp_out("bad_coin", 0, 0, 1, 190, 0, 0, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        exp_out("cancel190", 0, 0, 0, 190, 1, 190, 1);
        pulse_ack();
        exp_out("ack190", 0, 0, 0, 0, 0, 0, 0);
        coin(2'b11);
        exp_out("bad_idle", 0, 0, 1, 0, 0, 0, 0);

        // Cancel + select + coin in the same cycle
        coin(2'b10);
        coin(2'b10);
        cancel = 1'b1;
        select = 1'b1;
        coin_valid = 1'b1;
        coin_code = 2'b10;
        step();
        cancel = 1'b0;
        select = 1'b0;
        coin_valid = 1'b0;
        exp_out("conflict", 0, 0, 1, 50, 1, 50, 1);
        pulse_ack();

        // Select below price is ignored
        coin(2'b10);
        coin(2'b01);
        coin(2'b01);
        pulse_select();
        exp_out("sel45", 0, 0, 0, 45, 0, 0, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        pulse_ack();

        // Timeout abort: latch_clr 8 cycles after entering VEND, full refund
        coin(2'b10);
        coin(2'b10);
        pulse_select();
        exp_out("to_sel", 1, 0, 0, 50, 0, 0, 1);
        for (int i = 1; i < 8; i++) begin
            if (i == 3) begin
                coin_valid = 1'b1;
                coin_code  = 2'b00;
            end
            step();
            coin_valid = 1'b0;
            exp_out("to_wait", 0, 0, (i == 3), 50, 0, 0, 1);
        end
        step();
        exp_out("to_abort", 0, 1, 0, 50, 1, 50, 1);
        pulse_ack();
        exp_out("to_ack", 0, 0, 0, 0, 0, 0, 0);

        // dispense_done on the timeout cycle wins
        coin(2'b10);
        coin(2'b10);
        pulse_select();
        for (int i = 1; i < 8; i++) step();
        exp_out("race_wait", 0, 0, 0, 50, 0, 0, 1);
        dispense_done = 1'b1;
        step();
        dispense_done = 1'b0;
        exp_out("race_drop", 0, 1, 0, 0, 0, 0, 0);

        // Reset during VEND
        coin(2'b10);
        coin(2'b10);
        pulse_select();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_out("rst_vend", 0, 0, 0, 0, 0, 0, 0);
        step();
        exp_out("rst_vend_idle", 0, 0, 0, 0, 0, 0, 0);

        // Reset during CHANGE
        coin(2'b10);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        exp_out("pre_rst_chg", 0, 0, 0, 25, 1, 25, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_out("rst_chg", 0, 0, 0, 0, 0, 0, 0);
        coin(2'b01);
        exp_out("post_rst", 0, 0, 0, 10, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_credit_fsm.md
# vend_credit_fsm

Coin-credit controller for the vending machine, directly upstream of the dispense SR flip-flop. It accumulates inserted coins, authorises a vend when credit covers the price, and drives the flip-flop's set and reset inputs as single-cycle pulses. It also returns change and refunds on cancel or dispense timeout.

## Interface
Parameters:
- PRICE, 50: product price in cents.
- CREDIT_MAX, 200: maximum credit held, in cents.
- TIMEOUT, 1000: clock cycles allowed in VEND before abort.
- CW, 8: credit and change width in bits; must hold CREDIT_MAX.

Ports:
- clock, in, 1: single system clock, rising edge.
- reset, in, 1: synchronous, active-high; sampled on the rising edge of clock.
- coin_valid, in, 1: one-cycle strobe marking a coin insertion.
- coin_code, in, 2: 00 = 5c, 01 = 10c, 10 = 25c, 11 = invalid.
- select, in, 1: product request (level, sampled each cycle).
- cancel, in, 1: refund request (level, sampled each cycle).
- dispense_done, in, 1: one-cycle strobe from the mechanism when the product has dropped.
- change_ack, in, 1: change dispenser has taken change_amount.
- latch_set, out, 1: drives the dispense flip-flop set input; one-cycle pulse.
- latch_clr, out, 1: drives the dispense flip-flop reset input; one-cycle pulse.
- coin_reject, out, 1: one-cycle pulse; the coin sampled in the previous cycle was returned.
- credit, out, CW: current credit in cents.
- change_valid, out, 1: change_amount is valid; held until acknowledged.
- change_amount, out, CW: change or refund in cents.
- busy, out, 1: high in VEND and CHANGE.

## Operation
- States: IDLE, COLLECT, VEND, CHANGE. All outputs are registered.
- Reset values:
  - state = IDLE
  - credit = 0, change_amount = 0
  - all pulse outputs = 0
  - change_valid = 0, busy = 0
  - timeout counter = 0
- IDLE: a valid coin adds its value to credit and moves to COLLECT.
- COLLECT, priority order cancel > select > coin:
  - cancel: go to CHANGE with change_amount = credit. Any coin sampled in the same cycle is rejected.
  - select with credit >= PRICE: go to VEND and pulse latch_set. Any coin sampled in the same cycle is rejected.
  - select with credit < PRICE: ignored; stay in COLLECT.
  - coin: credit += value.
- Coin rejection: coin_reject pulses, and credit is unchanged, when any of the following holds:
  - coin_code is 11;
  - credit + value > CREDIT_MAX;
  - the state is VEND or CHANGE.
- VEND: the timeout counter increments every cycle.
  - On dispense_done: pulse latch_clr and set credit -= PRICE. If the remainder is greater than 0, go to CHANGE with change_amount = remainder. Otherwise go to IDLE.
  - When the counter reaches TIMEOUT-1 with no dispense_done: pulse latch_clr, refund the full credit (change_amount = credit), and go to CHANGE.
  - dispense_done in the same cycle as the timeout: dispense_done wins.
- CHANGE: hold change_valid = 1 and change_amount stable until change_ack is sampled. Then set credit = 0, change_valid = 0, and go to IDLE.
- Never assert latch_set and latch_clr in the same cycle.
- Arithmetic is unsigned, CW bits wide. The overflow check uses a CW+1-bit sum.
- Reset mid-operation:
  - All outputs return to their reset values and held credit is discarded.
  - A reset during VEND does not pulse latch_clr. The downstream flip-flop is cleared only by its own next latch_clr, so the system reset must also clear it.

## Timing
- The state-changing input is sampled at edge N; the resulting outputs are visible after edge N.
- latch_set is high for exactly the cycle after the select edge. The flip-flop output q rises at edge N+1.
- latch_clr is high for exactly the cycle after the dispense_done (or timeout) edge.
- Timeout abort happens exactly TIMEOUT cycles after entering VEND.
- coin_reject and credit update one cycle after coin_valid.
- change_valid rises together with entry to CHANGE and falls the cycle after change_ack.

## Structure
- Shared package/header vending_pkg holds:
  - coin code constants and their cent values;
  - state encodings IDLE/COLLECT/VEND/CHANGE (2 bits).
- Sub-module vend_timeout_counter: clear/enable inputs and a terminal pulse at TIMEOUT-1, parameterised on TIMEOUT. It is reset by the same synchronous reset.

## Test plan
- Reset, then coins 25 + 25, select:
  - credit 50;
  - latch_set pulses 1 cycle;
  - dispense_done then gives latch_clr pulse, credit 0, return to IDLE, change_valid never asserts.
- Coins 25, 25, 10, select, dispense_done:
  - change_valid = 1 with change_amount = 10, held until change_ack;
  - then credit 0 and IDLE.
- Overflow and invalid coins:
  - credit 190, insert 25: coin_reject pulses, credit stays 190;
  - coin_code 11: coin_reject pulses.
- Same-cycle conflicts:
  - credit 50, cancel + select + coin together: CHANGE with change_amount = 50, no latch_set, coin_reject = 1;
  - select with credit 45: no action.
- Timeout with TIMEOUT = 8:
  - no dispense_done: latch_clr exactly 8 cycles after entering VEND, refund of the full 50;
  - dispense_done on the 8th cycle instead: normal vend, no refund.
- Reset asserted in VEND and in CHANGE:
  - all outputs return to their reset values on the next edge, state IDLE, no latch pulses.
